spi_reg_ctrl: RTL and testbench
===============================

Name: spi_reg_ctrl

Overview:
- Register-access controller behind the SPI slave byte interface.
- Frames the slave's received byte stream using chip-select.
- Decodes a command byte, then performs auto-incrementing burst writes or reads on a simple single-port register bus.
- For reads, prefetches each register so it can be presented on the slave's transmit byte before the next SPI byte starts shifting out.

Parameters:
ADDR_W, 7, register address width; the command byte carries the address in bits [ADDR_W-1:0] (ADDR_W ≤ 7).
STATUS_BYTE, 8'h5A, byte loaded on tx_byte while the command byte is being received.

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
cs  input  1  raw SPI chip-select from pad, active-low, asynchronous to clk
rx_byte  input  8  received byte from SPI slave, valid when rx_valid is high
rx_valid  input  1  one-clk pulse per completed received byte
tx_byte  output  8  byte for the SPI slave to shift out next; held stable between updates
reg_addr  output  ADDR_W  register bus address
reg_wr_en  output  1  one-clk write strobe
reg_wdata  output  8  write data
reg_rd_en  output  1  one-clk read strobe
reg_rdata  input  8  read data, valid the clk after reg_rd_en
busy  output  1  high while a frame is open (synchronised cs low)
ovr_err  output  1  sticky overrun flag for the current frame

Behaviour:
- Reset values: tx_byte=STATUS_BYTE, reg_addr=0, reg_wr_en=0, reg_wdata=0, reg_rd_en=0, busy=0, ovr_err=0, state=IDLE, internal address=0.
- Reset values for cs synchroniser flops: both 1.
- cs synchronisation: 2-flop synchroniser followed by an edge detector on the synchronised value.
- All outputs are registered.
- Command byte: bit7 = RW (1 = read, 0 = write); bits[ADDR_W-1:0] = start address; any remaining bits are ignored.
- State IDLE: busy=0; rx_valid is ignored.
  - On a synchronised cs fall: go to CMD, set busy=1, tx_byte←STATUS_BYTE, clear ovr_err.
- State CMD: on rx_valid, load the address from the command byte.
  - RW=0: go to WR.
  - RW=1: go to RD_REQ.
- State WR: on rx_valid, in the next clk assert reg_wr_en=1 for 1 clk with reg_addr=address and reg_wdata=rx_byte; then address←address+1.
- State RD_REQ (1 clk): reg_rd_en=1, reg_addr=address; go to RD_CAP.
- State RD_CAP (1 clk): tx_byte←reg_rdata, address←address+1; go to RD.
- State RD: on rx_valid, go to RD_REQ. The received byte is discarded.
- Read latency: rx_valid at clk T → reg_rd_en high in T+1 → tx_byte updated and visible from T+3.
- Address wrap: incrementing from 2^ADDR_W-1 gives 0.
- Overrun: rx_valid arriving while in RD_REQ or RD_CAP sets ovr_err=1.
  - The extra byte is otherwise ignored and the sequence completes normally.
  - ovr_err holds until the next frame start or reset.
- Frame end: a synchronised cs rise from any state goes to IDLE and sets busy=0.
  - tx_byte keeps its value.
  - Any in-flight read strobe or capture is abandoned.
  - If rx_valid coincides with the cs rise while in WR, that write is still issued.
- Strobes: reg_wr_en and reg_rd_en are never high in the same clk and never high for 2 consecutive clks.
- Reset mid-frame: rst wins over all events; the block returns to the reset values immediately.
- System constraints (documented, not checked):
  - SCK ≤ clk/16 for reads.
  - cs held low ≥ 8 clk after the last SCK rising edge.

Test Plan:
- Write burst: cs low, bytes 8'h05, 8'h11, 8'h22, 8'h33, cs high → reg_wr_en pulses at addresses 5, 6, 7 with data 11/22/33; no reg_rd_en; busy falls about 2 clk after cs rises.
- Read burst: registers 10→8'hA1, 11→8'hB2; bytes 8'h8A, 8'h00, 8'h00 → tx_byte=5A during the command byte, then A1 from 3 clk after the first rx_valid, then B2 from 3 clk after the second; reg_rd_en at addresses 10 then 11.
- Wrap: write command 8'h7F, two data bytes 8'hC0, 8'hC1 (ADDR_W=7) → writes to addresses 127 then 0.
- Overrun: in a read, pulse rx_valid 1 clk after the previous one → ovr_err=1 and exactly one reg_rd_en; a new frame start clears ovr_err.
- Abort: cs rises in the clk of reg_rd_en → state IDLE; tx_byte unchanged; next frame begins in CMD with tx_byte=5A.
- Reset: assert rst mid write burst → all outputs at reset values the next clk; after rst releases, rx_valid with cs high produces no strobes.

Source files
------------

// File: rtl/spi_reg_ctrl.sv
// -----------------------------------------------------------------------------
// spi_reg_ctrl
//
// Register-access controller that sits behind an SPI slave byte interface.
// A frame is delimited by chip-select. The first byte of a frame is a command
// (bit7 = read/not-write, low bits = start address). It is followed by
// auto-incrementing burst writes or reads on a single-port register bus.
// Reads are prefetched so the next byte to shift out is already on tx_byte.
//
// Ports:
//   clk        system clock
//   rst        synchronous reset, active-high
//   cs         raw SPI chip-select (active-low, asynchronous to clk)
//   rx_byte    received byte, qualified by rx_valid
//   rx_valid   one-clk pulse per completed received byte
//   tx_byte    byte the SPI slave shifts out next
//   reg_addr   register bus address
//   reg_wr_en  one-clk write strobe
//   reg_wdata  write data
//   reg_rd_en  one-clk read strobe
//   reg_rdata  read data, valid the clk after reg_rd_en
//   busy       frame open (synchronised cs low)
//   ovr_err    sticky overrun flag, cleared at frame start
// -----------------------------------------------------------------------------
module spi_reg_ctrl #(
  parameter int         ADDR_W      = 7,
  parameter logic [7:0] STATUS_BYTE = 8'h5A
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic [7:0]        rx_byte,
  input  logic              rx_valid,
  output logic [7:0]        tx_byte,
  output logic [ADDR_W-1:0] reg_addr,
  output logic              reg_wr_en,
  output logic [7:0]        reg_wdata,
  output logic              reg_rd_en,
  input  logic [7:0]        reg_rdata,
  output logic              busy,
  output logic              ovr_err
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] CMD    = 3'd1;
  localparam logic [2:0] WR     = 3'd2;
  localparam logic [2:0] RD_REQ = 3'd3;
  localparam logic [2:0] RD_CAP = 3'd4;
  localparam logic [2:0] RD     = 3'd5;

  // cs synchroniser (meta, sync) plus previous synchronised value for edges
  logic cs_meta_q, cs_sync_q, cs_prev_q;
  logic cs_fall, cs_rise;

  logic [2:0]        state_q,    state_d;
  logic [ADDR_W-1:0] addr_q,     addr_d;
  logic [7:0]        tx_q,       tx_d;
  logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
  logic              wr_en_q,    wr_en_d;
  logic [7:0]        wdata_q,    wdata_d;
  logic              rd_en_q,    rd_en_d;
  logic              busy_q,     busy_d;
  logic              ovr_q,      ovr_d;

  assign cs_fall = cs_prev_q & ~cs_sync_q;
  assign cs_rise = ~cs_prev_q & cs_sync_q;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    tx_d       = tx_q;
    reg_addr_d = reg_addr_q;
    wr_en_d    = 1'b0;
    wdata_d    = wdata_q;
    rd_en_d    = 1'b0;
    busy_d     = busy_q;
    ovr_d      = ovr_q;

    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d = CMD;
          busy_d  = 1'b1;
          tx_d    = STATUS_BYTE;
          ovr_d   = 1'b0;
        end
      end
      CMD: begin
        if (rx_valid) begin
          addr_d = rx_byte[ADDR_W-1:0];
          if (rx_byte[7]) begin
            // Issue the first read straight from the command byte so the
            // strobe lands one clk after rx_valid.
            state_d    = RD_REQ;
            rd_en_d    = 1'b1;
            reg_addr_d = rx_byte[ADDR_W-1:0];
          end else begin
            state_d = WR;
          end
        end
      end
      WR: begin
        if (rx_valid) begin
          wr_en_d    = 1'b1;
          reg_addr_d = addr_q;
          wdata_d    = rx_byte;
          addr_d     = addr_q + 1'b1;
        end
      end
      RD_REQ: begin
        state_d = RD_CAP;
        if (rx_valid) ovr_d = 1'b1;
      end
      RD_CAP: begin
        tx_d    = reg_rdata;
        addr_d  = addr_q + 1'b1;
        state_d = RD;
        if (rx_valid) ovr_d = 1'b1;
      end
      RD: begin
        // Received byte during a read burst is a dummy; only its timing matters.
        if (rx_valid) begin
          state_d    = RD_REQ;
          rd_en_d    = 1'b1;
          reg_addr_d = addr_q;
        end
      end
      default: state_d = IDLE;
    endcase

    // Frame end overrides everything except a write already accepted in WR,
    // which is allowed to complete. Reads in flight are dropped.
    if (cs_rise) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      rd_en_d = 1'b0;
      tx_d    = tx_q;
      if (state_q != WR) begin
        addr_d     = addr_q;
        reg_addr_d = reg_addr_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cs_meta_q  <= 1'b1;
      cs_sync_q  <= 1'b1;
      cs_prev_q  <= 1'b1;
      state_q    <= IDLE;
      addr_q     <= '0;
      tx_q       <= STATUS_BYTE;
      reg_addr_q <= '0;
      wr_en_q    <= 1'b0;
      wdata_q    <= 8'h00;
      rd_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      cs_meta_q  <= cs;
      cs_sync_q  <= cs_meta_q;
      cs_prev_q  <= cs_sync_q;
      state_q    <= state_d;
      addr_q     <= addr_d;
      tx_q       <= tx_d;
      reg_addr_q <= reg_addr_d;
      wr_en_q    <= wr_en_d;
      wdata_q    <= wdata_d;
      rd_en_q    <= rd_en_d;
      busy_q     <= busy_d;
      ovr_q      <= ovr_d;
    end
  end

  assign tx_byte   = tx_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wr_en = wr_en_q;
  assign reg_wdata = wdata_q;
  assign reg_rd_en = rd_en_q;
  assign busy      = busy_q;
  assign ovr_err   = ovr_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
module tb_spi_reg_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cs;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic [7:0] tx_byte;
  logic [6:0] reg_addr;
  logic       reg_wr_en;
  logic [7:0] reg_wdata;
  logic       reg_rd_en;
  logic [7:0] reg_rdata;
  logic       busy;
  logic       ovr_err;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  int strobe_viol = 0;
  logic prev_strobe = 1'b0;
  logic [7:0] mem [0:127];

  always #5 clk = ~clk;

  spi_reg_ctrl #(.ADDR_W(7), .STATUS_BYTE(8'h5A)) dut (
    .clk(clk), .rst(rst), .cs(cs), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .tx_byte(tx_byte), .reg_addr(reg_addr), .reg_wr_en(reg_wr_en),
    .reg_wdata(reg_wdata), .reg_rd_en(reg_rd_en), .reg_rdata(reg_rdata),
    .busy(busy), .ovr_err(ovr_err)
  );

  // Register bus model: read data appears the clk after the read strobe.
  always @(posedge clk) begin
    if (reg_rd_en) reg_rdata <= mem[reg_addr];
    if (reg_wr_en) begin
      wr_cnt = wr_cnt + 1;
      $display("bus write addr=%0d data=%02h", reg_addr, reg_wdata);
    end
    if (reg_rd_en) begin
      rd_cnt = rd_cnt + 1;
      $display("bus read  addr=%0d", reg_addr);
    end
    if (reg_wr_en && reg_rd_en) strobe_viol = strobe_viol + 1;
    if ((reg_wr_en || reg_rd_en) && prev_strobe) strobe_viol = strobe_viol + 1;
    prev_strobe = reg_wr_en | reg_rd_en;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      $display("check %s: observed %0h expected %0h ok", tag, obs, exp);
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
    $display("spi byte %02h delivered at %0t", b, $time);
  endtask

  task automatic frame_start();
    cs = 1'b0;
    tick(4);
  endtask

  task automatic frame_end();
    cs = 1'b1;
    tick(4);
  endtask

  int w0, r0;

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    mem[10] = 8'hA1;
    mem[11] = 8'hB2;
    mem[12] = 8'hC3;
    reg_rdata = 8'h00;
    rst = 1'b1; cs = 1'b1; rx_byte = 8'h00; rx_valid = 1'b0;
    tick(3);

    // Reset state
    chk("rst_tx", tx_byte, 8'h5A);
    chk("rst_addr", reg_addr, 0);
    chk("rst_wr", reg_wr_en, 0);
    chk("rst_wdata", reg_wdata, 0);
    chk("rst_rd", reg_rd_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovr", ovr_err, 0);
    rst = 1'b0;
    tick(2);

    // Write burst to 5,6,7
    w0 = wr_cnt; r0 = rd_cnt;
    frame_start();
    chk("wr_busy", busy, 1);
    chk("wr_tx_status", tx_byte, 8'h5A);
    send_byte(8'h05); tick(12);
    send_byte(8'h11);
    chk("wr0_en", reg_wr_en, 1);
    chk("wr0_addr", reg_addr, 5);
    chk("wr0_data", reg_wdata, 8'h11);
    tick(1);
    chk("wr0_pulse_end", reg_wr_en, 0);
    tick(11);
    send_byte(8'h22);
    chk("wr1_addr", reg_addr, 6);
    chk("wr1_data", reg_wdata, 8'h22);
    tick(12);
    send_byte(8'h33);
    chk("wr2_addr", reg_addr, 7);
    chk("wr2_data", reg_wdata, 8'h33);
    tick(12);
    cs = 1'b1;
    tick(1);
    chk("wr_busy_hold", busy, 1);
    tick(2);
    chk("wr_busy_fall", busy, 0);
    tick(2);
    chk("wr_count", wr_cnt - w0, 3);
    chk("wr_no_reads", rd_cnt - r0, 0);

    // Read burst from 10
    w0 = wr_cnt; r0 = rd_cnt;
    frame_start();
    chk("rd_tx_status", tx_byte, 8'h5A);
    send_byte(8'h8A);
    chk("rd0_en", reg_rd_en, 1);
    chk("rd0_addr", reg_addr, 10);
    tick(1);
    chk("rd0_tx_not_yet", tx_byte, 8'h5A);
    tick(1);
    chk("rd0_tx", tx_byte, 8'hA1);
    tick(12);
    send_byte(8'h00);
    chk("rd1_addr", reg_addr, 11);
    tick(1);
    chk("rd1_tx_not_yet", tx_byte, 8'hA1);
    tick(1);
    chk("rd1_tx", tx_byte, 8'hB2);
    tick(12);
    send_byte(8'h00);
    tick(2);
    chk("rd2_tx", tx_byte, 8'hC3);
    tick(10);
    frame_end();
    chk("rd_count", rd_cnt - r0, 3);
    chk("rd_no_writes", wr_cnt - w0, 0);
    chk("rd_tx_after_end", tx_byte, 8'hC3);

    // Address wrap
    frame_start();
    send_byte(8'h7F); tick(12);
    send_byte(8'hC0);
    chk("wrap0_addr", reg_addr, 127);
    chk("wrap0_data", reg_wdata, 8'hC0);
    tick(12);
    send_byte(8'hC1);
    chk("wrap1_en", reg_wr_en, 1);
    chk("wrap1_addr", reg_addr, 0);
    chk("wrap1_data", reg_wdata, 8'hC1);
    tick(12);
    frame_end();

    // Overrun
    r0 = rd_cnt;
    frame_start();
    chk("ovr_clear_start", ovr_err, 0);
    send_byte(8'h8A);
    send_byte(8'hEE);
    tick(6);
    chk("ovr_set", ovr_err, 1);
    chk("ovr_one_read", rd_cnt - r0, 1);
    chk("ovr_tx_completed", tx_byte, 8'hA1);
    frame_end();
    chk("ovr_sticky", ovr_err, 1);
    frame_start();
    chk("ovr_cleared_new_frame", ovr_err, 0);
    frame_end();

    // Abort during read strobe
    r0 = rd_cnt; w0 = wr_cnt;
    frame_start();
    send_byte(8'h8A); tick(12);
    chk("abort_tx_before", tx_byte, 8'hA1);
    cs = 1'b1;
    tick(1);
    send_byte(8'h00);
    chk("abort_rd_en", reg_rd_en, 1);
    tick(1);
    chk("abort_idle", busy, 0);
    tick(4);
    chk("abort_tx_kept", tx_byte, 8'hA1);
    frame_start();
    chk("abort_new_busy", busy, 1);
    chk("abort_new_tx", tx_byte, 8'h5A);
    send_byte(8'h0C); tick(12);
    send_byte(8'h77);
    chk("abort_new_wr_addr", reg_addr, 12);
    chk("abort_new_wr_data", reg_wdata, 8'h77);
    tick(12);
    frame_end();
    chk("abort_reads", rd_cnt - r0, 2);
    chk("abort_writes", wr_cnt - w0, 1);

    // Reset mid write burst
    frame_start();
    send_byte(8'h03); tick(12);
    send_byte(8'h44);
    chk("mid_wr_addr", reg_addr, 3);
    tick(12);
    rst = 1'b1; cs = 1'b1; rx_byte = 8'h55; rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
    chk("mid_rst_tx", tx_byte, 8'h5A);
    chk("mid_rst_addr", reg_addr, 0);
    chk("mid_rst_wr", reg_wr_en, 0);
    chk("mid_rst_wdata", reg_wdata, 0);
    chk("mid_rst_rd", reg_rd_en, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ovr", ovr_err, 0);
    rst = 1'b0;
    tick(3);
    w0 = wr_cnt; r0 = rd_cnt;
    send_byte(8'h85); tick(5);
    send_byte(8'h12); tick(5);
    chk("post_rst_no_wr", wr_cnt - w0, 0);
    chk("post_rst_no_rd", rd_cnt - r0, 0);
    chk("post_rst_busy", busy, 0);

    chk("strobe_rules", strobe_viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
